// File: rtl/sweep_amp_meter_if.sv
// Sample-stream and result bus of the windowed amplitude meter.
// The master drives the sample enable, run request and sample. The slave
// (the meter) returns run status and the per-window results.
interface sweep_amp_meter_if #(
  parameter int DW   = 12,
  parameter int NWIN = 64
) ();

  localparam int IDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;

  // sample side
  logic                 i_en;
  logic                 i_start;
  logic signed [DW-1:0] i_in;

  // status and results
  logic                 o_busy;
  logic                 o_done;
  logic                 o_res_valid;
  logic [IDX_W-1:0]     o_res_idx;
  logic signed [DW-1:0] o_res_max;
  logic signed [DW-1:0] o_res_min;
  logic [DW:0]          o_res_ppk;
  logic [DW-1:0]        o_res_mabs;

  modport master (
    output i_en, i_start, i_in,
    input  o_busy, o_done, o_res_valid, o_res_idx,
           o_res_max, o_res_min, o_res_ppk, o_res_mabs
  );

  modport slave (
    input  i_en, i_start, i_in,
    output o_busy, o_done, o_res_valid, o_res_idx,
           o_res_max, o_res_min, o_res_ppk, o_res_mabs
  );

endinterface

// File: rtl/sweep_amp_meter.sv
// Windowed amplitude meter. After a start request it drops SETTLE accepted
// samples (filter fill-up), then cuts the stream into NWIN back-to-back
// windows of 2^WIN_LOG2 accepted samples and reports max, min, peak-to-peak
// and mean absolute value for each window.
module sweep_amp_meter #(
  parameter int DW       = 12,
  parameter int WIN_LOG2 = 8,
  parameter int SETTLE   = 32,
  parameter int NWIN     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  sweep_amp_meter_if.slave   bus
);

  localparam int IDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int SC_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int AW    = DW + WIN_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // run counters
  logic [SC_W-1:0]      r_settle_cnt;
  logic [WIN_LOG2-1:0]  r_samp_cnt;
  logic [IDX_W-1:0]     r_idx;

  // per-window trackers
  logic signed [DW-1:0] r_max;
  logic signed [DW-1:0] r_min;
  logic [AW-1:0]        r_acc;

  // registered results
  logic                 r_res_valid;
  logic [IDX_W-1:0]     r_res_idx;
  logic signed [DW-1:0] r_res_max;
  logic signed [DW-1:0] r_res_min;
  logic [DW:0]          r_res_ppk;
  logic [DW-1:0]        r_res_mabs;

  // datapath wires
  logic [DW-1:0]        w_abs;
  logic                 w_first;
  logic signed [DW-1:0] w_max_new;
  logic signed [DW-1:0] w_min_new;
  logic [AW-1:0]        w_acc_new;
  logic                 w_win_end;
  logic                 w_last_win;
  logic                 w_settle_end;
  logic [DW:0]          w_ppk;
  logic [DW-1:0]        w_mabs;

  // |in| kept in DW unsigned bits so the most negative code maps to 2^(DW-1)
  assign w_abs = bus.i_in[DW-1] ? $unsigned(-bus.i_in) : $unsigned(bus.i_in);

  // the first sample of a window loads both trackers regardless of history
  assign w_first   = (r_samp_cnt == '0);
  assign w_max_new = (w_first || (bus.i_in > r_max)) ? bus.i_in : r_max;
  assign w_min_new = (w_first || (bus.i_in < r_min)) ? bus.i_in : r_min;
  assign w_acc_new = r_acc + AW'(w_abs);

  assign w_win_end    = (r_state == ST_MEASURE) && bus.i_en && (r_samp_cnt == '1);
  assign w_last_win   = (r_idx == IDX_W'(NWIN - 1));
  assign w_settle_end = (r_settle_cnt == SC_W'(SETTLE - 1));

  // one extra bit holds the full max-min span; max >= min so the
  // modular difference is the true unsigned span
  assign w_ppk  = {w_max_new[DW-1], w_max_new} - {w_min_new[DW-1], w_min_new};
  assign w_mabs = w_acc_new[AW-1:WIN_LOG2];

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state logic: start wins over every other transition
  always_comb begin
    w_state_next = r_state;
    if (bus.i_start) begin
      w_state_next = (SETTLE == 0) ? ST_MEASURE : ST_SETTLE;
    end else if (bus.i_en) begin
      case (r_state)
        ST_SETTLE:  if (w_settle_end) w_state_next = ST_MEASURE;
        ST_MEASURE: if (w_win_end && w_last_win) w_state_next = ST_DONE;
        default:    w_state_next = r_state;
      endcase
    end
  end

  // counters, trackers and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_samp_cnt   <= '0;
      r_idx        <= '0;
      r_max        <= '0;
      r_min        <= '0;
      r_acc        <= '0;
      r_res_valid  <= 1'b0;
      r_res_idx    <= '0;
      r_res_max    <= '0;
      r_res_min    <= '0;
      r_res_ppk    <= '0;
      r_res_mabs   <= '0;
    end else begin
      r_res_valid <= 1'b0;
      if (bus.i_start) begin
        // abort anything in flight; a partial window never reports
        r_settle_cnt <= '0;
        r_samp_cnt   <= '0;
        r_idx        <= '0;
        r_max        <= '0;
        r_min        <= '0;
        r_acc        <= '0;
      end else if (bus.i_en) begin
        if (r_state == ST_SETTLE) begin
          r_settle_cnt <= r_settle_cnt + SC_W'(1);
        end else if (r_state == ST_MEASURE) begin
          // sample counter wraps to zero at window end, so the next
          // window starts on the very next accepted sample
          r_samp_cnt <= r_samp_cnt + WIN_LOG2'(1);
          if (w_win_end) begin
            r_res_valid <= 1'b1;
            r_res_idx   <= r_idx;
            r_res_max   <= w_max_new;
            r_res_min   <= w_min_new;
            r_res_ppk   <= w_ppk;
            r_res_mabs  <= w_mabs;
            r_max       <= '0;
            r_min       <= '0;
            r_acc       <= '0;
            r_idx       <= w_last_win ? '0 : r_idx + IDX_W'(1);
          end else begin
            r_max <= w_max_new;
            r_min <= w_min_new;
            r_acc <= w_acc_new;
          end
        end
      end
    end
  end

  assign bus.o_busy      = (r_state == ST_SETTLE) || (r_state == ST_MEASURE);
  assign bus.o_done      = (r_state == ST_DONE);
  assign bus.o_res_valid = r_res_valid;
  assign bus.o_res_idx   = r_res_idx;
  assign bus.o_res_max   = r_res_max;
  assign bus.o_res_min   = r_res_min;
  assign bus.o_res_ppk   = r_res_ppk;
  assign bus.o_res_mabs  = r_res_mabs;

endmodule
